// File: rtl/psk_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psk_pkg
// Brief    : Shared types and constants for the PSK frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package psk_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int          SYM_PER_BYTE_QPSK = 4;
    localparam int          SYM_PER_BYTE_BPSK = 8;
    localparam logic [31:0] PREAMBLE_DEFAULT  = 32'hAAAA_AA5D;

    // Map the two MSBs of a byte to a symbol: BPSK repeats the top bit,
    // QPSK sends the dibit as-is.
    function automatic logic [1:0] map_sym(input logic [1:0] top2, input logic is_bpsk);
        return is_bpsk ? {top2[1], top2[1]} : top2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psk_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : psk_frame_sched_if
// Brief    : Upstream byte stream and modulator symbol stream of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface psk_frame_sched_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       m_tuser;

    // Sequencer side
    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );

    // Environment side (byte FIFO + modulator)
    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface
`default_nettype wire

// File: rtl/psk_frame_sched_serializer.sv
`default_nettype none
// ============================================================================
// Module   : psk_sym_serializer
// Brief    : Byte shift register, per-byte symbol counter and symbol mapping.
//            The shift register always holds the next symbol to present; a
//            load presents the new byte's first symbol directly.
// Revision : 1.0 - initial release
// ============================================================================
module psk_sym_serializer
    import psk_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_byte,
    input  wire logic       i_mode,
    input  wire logic       i_advance,
    output logic      [1:0] o_sym,
    output logic            o_byte_done,
    output logic            o_last_sym
);

    logic [7:0] r_shift;
    logic [3:0] r_remain;
    logic [3:0] w_per_byte;

    assign w_per_byte  = i_mode ? 4'(SYM_PER_BYTE_BPSK) : 4'(SYM_PER_BYTE_QPSK);
    assign o_sym       = map_sym(i_load ? i_byte[7:6] : r_shift[7:6], i_mode);
    assign o_byte_done = (r_remain == 4'd0);
    assign o_last_sym  = (r_remain == 4'd1);

    // Load consumes the first symbol immediately; advance shifts out one more
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_shift  <= i_mode ? {i_byte[6:0], 1'b0} : {i_byte[5:0], 2'b00};
            r_remain <= w_per_byte - 4'd1;
        end else if (i_advance && !o_byte_done) begin
            r_shift  <= i_mode ? {r_shift[6:0], 1'b0} : {r_shift[5:0], 2'b00};
            r_remain <= r_remain - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psk_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : psk_frame_sched
// Brief    : Frame sequencer for the PSK modulator: BPSK preamble, payload as
//            BPSK bits or QPSK dibits, then an idle gap. Advances only on
//            modulator symbol slots (m_tready & clk_enable).
// Revision : 1.0 - initial release
// ============================================================================
module psk_frame_sched
    import psk_pkg::*;
#(
    parameter int          PRE_LEN  = 32,
    parameter logic [31:0] PREAMBLE = PREAMBLE_DEFAULT,
    parameter int          GAP_SYMS = 8
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clk_enable,
    input  wire logic          cfg_enable,
    input  wire logic          cfg_is_bpsk,
    psk_frame_sched_if.master  bus,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun
);

    state_t     r_state,    w_state_nxt;
    logic       r_mode,     w_mode_nxt;
    logic       r_last,     w_last_nxt;
    logic [4:0] r_pre_idx,  w_pre_idx_nxt;
    logic [7:0] r_gap_cnt,  w_gap_nxt;
    logic       r_underrun, w_under_nxt;
    logic [1:0] r_m_tdata,  w_tdata_nxt;
    logic       r_m_tvalid, w_tvalid_nxt;
    logic       r_m_tlast,  w_tlast_nxt;
    logic       r_m_tuser,  w_tuser_nxt;

    logic       w_slot;
    logic       w_fetch_due;
    logic       w_take;
    logic       w_advance;
    logic [4:0] w_pre_idx_m1;
    logic [1:0] w_ser_sym;
    logic       w_ser_done;
    logic       w_ser_last;

    assign w_slot       = clk_enable & bus.m_tready;
    // A byte is due after the last preamble bit, or after a non-final byte is used up
    assign w_fetch_due  = ((r_state == ST_PRE) && (r_pre_idx == 5'd0)) ||
                          ((r_state == ST_PAY) && w_ser_done && !r_last);
    assign w_take       = w_slot & w_fetch_due & bus.s_tvalid & ~rst;
    assign w_advance    = w_slot & (r_state == ST_PAY) & ~w_ser_done;
    assign w_pre_idx_m1 = r_pre_idx - 5'd1;

    assign bus.s_tready = w_take;
    assign bus.m_tdata  = {6'b0, r_m_tdata};
    assign bus.m_tvalid = r_m_tvalid;
    assign bus.m_tlast  = r_m_tlast;
    assign bus.m_tuser  = r_m_tuser;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = w_slot & (r_state == ST_PAY) & w_ser_done & r_last & ~rst;
    assign underrun     = r_underrun;

    psk_sym_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_take),
        .i_byte      (bus.s_tdata),
        .i_mode      (r_mode),
        .i_advance   (w_advance),
        .o_sym       (w_ser_sym),
        .o_byte_done (w_ser_done),
        .o_last_sym  (w_ser_last)
    );

    // Next state and next presented symbol; nothing moves outside a slot
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_last_nxt    = r_last;
        w_pre_idx_nxt = r_pre_idx;
        w_gap_nxt     = r_gap_cnt;
        w_under_nxt   = r_underrun;
        w_tdata_nxt   = r_m_tdata;
        w_tvalid_nxt  = r_m_tvalid;
        w_tlast_nxt   = r_m_tlast;
        w_tuser_nxt   = r_m_tuser;
        if (w_slot) begin
            // Every slot replaces the symbol; invalid unless overridden below
            w_tdata_nxt  = 2'b00;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_tuser_nxt  = 1'b0;
            if (w_fetch_due) begin
                // Missing byte: send an empty symbol and retry next slot
                w_state_nxt = ST_PAY;
                if (bus.s_tvalid) begin
                    w_tdata_nxt  = w_ser_sym;
                    w_tvalid_nxt = 1'b1;
                    w_tuser_nxt  = r_mode;
                    w_last_nxt   = bus.s_tlast;
                end else begin
                    w_under_nxt  = 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_enable && bus.s_tvalid) begin
                            w_mode_nxt    = cfg_is_bpsk;
                            w_last_nxt    = 1'b0;
                            w_pre_idx_nxt = 5'(PRE_LEN - 1);
                            w_tdata_nxt   = {2{PREAMBLE[PRE_LEN-1]}};
                            w_tvalid_nxt  = 1'b1;
                            w_tuser_nxt   = 1'b1;
                            w_state_nxt   = ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        w_pre_idx_nxt = w_pre_idx_m1;
                        w_tdata_nxt   = {2{PREAMBLE[w_pre_idx_m1]}};
                        w_tvalid_nxt  = 1'b1;
                        w_tuser_nxt   = 1'b1;
                    end
                    ST_PAY: begin
                        if (w_ser_done) begin
                            // Final symbol of the frame consumed
                            w_gap_nxt   = 8'(GAP_SYMS);
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_tdata_nxt  = w_ser_sym;
                            w_tvalid_nxt = 1'b1;
                            w_tuser_nxt  = r_mode;
                            w_tlast_nxt  = r_last & w_ser_last;
                        end
                    end
                    ST_GAP: begin
                        w_gap_nxt = r_gap_cnt - 8'd1;
                        if (r_gap_cnt == 8'd1) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // State and presented-symbol registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_last     <= 1'b0;
            r_pre_idx  <= '0;
            r_gap_cnt  <= '0;
            r_underrun <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_last     <= w_last_nxt;
            r_pre_idx  <= w_pre_idx_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_underrun <= w_under_nxt;
            r_m_tdata  <= w_tdata_nxt;
            r_m_tvalid <= w_tvalid_nxt;
            r_m_tlast  <= w_tlast_nxt;
            r_m_tuser  <= w_tuser_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psk_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_psk_frame_sched
// Brief    : Self-checking bench for psk_frame_sched with a symbol scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psk_frame_sched;

    localparam int          PRE_LEN  = 32;
    localparam logic [31:0] PREAMBLE = 32'hAAAA_AA5D;
    localparam int          GAP_SYMS = 8;

    logic clk = 1'b0;
    logic rst, clk_enable, cfg_enable, cfg_is_bpsk;
    logic busy, frame_done, underrun;

    psk_frame_sched_if bus();

    psk_frame_sched #(
        .PRE_LEN  (PRE_LEN),
        .PREAMBLE (PREAMBLE),
        .GAP_SYMS (GAP_SYMS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_enable  (clk_enable),
        .cfg_enable  (cfg_enable),
        .cfg_is_bpsk (cfg_is_bpsk),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_pass = 0;
    logic [9:0] exp_q[$];   // {tlast, tuser, tdata}
    logic [8:0] src_q[$];   // {tlast, byte}
    int         slot_cnt = 0, n_tready = 0, n_done = 0;
    int         last_done_slot = 0, last_gap = 0, cur_inv = 0, last_frame_inv = 0;
    bit         in_frame = 0, took = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_preamble();
        for (int i = PRE_LEN - 1; i >= 0; i--)
            exp_q.push_back({1'b0, 1'b1, 6'b0, {2{PREAMBLE[i]}}});
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last, input logic bpsk);
        int n;
        logic [1:0] s;
        n = bpsk ? 8 : 4;
        src_q.push_back({last, b});
        for (int i = 0; i < n; i++) begin
            if (bpsk) s = {b[7-i], b[7-i]};
            else      s = {b[7-2*i], b[6-2*i]};
            exp_q.push_back({last && (i == n - 1), bpsk, 6'b0, s});
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int cyc = 0;
        while (n_done < target && cyc < 4000) begin @(posedge clk); #2; cyc++; end
        check({tag, "_done_timeout"}, 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_tready(input int target, input string tag);
        int cyc = 0;
        while (n_tready < target && cyc < 4000) begin @(posedge clk); #2; cyc++; end
        check({tag, "_tready_timeout"}, 32'(n_tready >= target), 32'd1);
    endtask

    task automatic wait_slots(input int n);
        int target;
        int cyc = 0;
        target = slot_cnt + n;
        while (slot_cnt < target && cyc < 16 * n + 64) begin @(posedge clk); #2; cyc++; end
        check("slot_wait_timeout", 32'(slot_cnt >= target), 32'd1);
    endtask

    // Symbol slot: one clk_enable pulse every 16 clocks
    initial begin
        clk_enable = 1'b0;
        bus.m_tready = 1'b1;
        forever begin
            repeat (15) @(posedge clk);
            #1 clk_enable = 1'b1;
            @(posedge clk);
            #1 clk_enable = 1'b0;
        end
    end

    // Upstream byte source fed from src_q
    initial begin
        bus.s_tvalid = 1'b0; bus.s_tdata = 8'h00; bus.s_tlast = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (took) begin
                took = 0;
                if (src_q.size() > 0) src_q.delete(0);
            end
            if (src_q.size() > 0) begin
                {bus.s_tlast, bus.s_tdata} = src_q[0];
                bus.s_tvalid = 1'b1;
            end else begin
                bus.s_tvalid = 1'b0; bus.s_tdata = 8'h00; bus.s_tlast = 1'b0;
            end
        end
    end

    // Monitor: compares every consumed valid symbol against the scoreboard
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
            end else begin
                if (bus.s_tready) begin n_tready++; took = 1; end
                if (frame_done)
                    check("frame_done_on_tlast_slot",
                          {29'b0, clk_enable & bus.m_tready, bus.m_tvalid, bus.m_tlast}, 32'h7);
                if (clk_enable && bus.m_tready) begin
                    if (bus.m_tvalid) begin
                        if (!in_frame) begin
                            in_frame = 1; cur_inv = 0;
                            last_gap = slot_cnt - last_done_slot;
                        end
                        check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("symbol", {22'b0, bus.m_tlast, bus.m_tuser, bus.m_tdata}, {22'b0, e});
                        end
                    end else if (in_frame) begin
                        cur_inv++;
                    end
                    if (frame_done) begin
                        n_done++;
                        last_done_slot = slot_cnt;
                        last_frame_inv = cur_inv;
                        in_frame = 0;
                    end
                    slot_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dbase, s, cyc;
        rst = 1'b1; cfg_enable = 1'b0; cfg_is_bpsk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid",    32'(bus.m_tvalid), 32'd0);
        check("rst_m_tdata",     32'(bus.m_tdata),  32'd0);
        check("rst_m_tlast_user",{30'b0, bus.m_tlast, bus.m_tuser}, 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_frame_done",  32'(frame_done),  32'd0);
        check("rst_underrun",    32'(underrun),    32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // QPSK frame B4,1E
        push_preamble();
        push_byte(8'hB4, 1'b0, 1'b0);
        push_byte(8'h1E, 1'b1, 1'b0);
        base = n_tready;
        cfg_enable = 1'b1;
        wait_done(1, "qpsk");
        check("qpsk_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("qpsk_no_invalid", 32'(last_frame_inv), 32'd0);
        check("qpsk_bytes_taken", 32'(n_tready - base), 32'd2);
        check("qpsk_no_underrun", 32'(underrun), 32'd0);

        // BPSK single-byte frame 81
        cfg_is_bpsk = 1'b1;
        push_preamble();
        push_byte(8'h81, 1'b1, 1'b1);
        base = n_tready;
        wait_done(2, "bpsk");
        check("bpsk_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("bpsk_tready_once", 32'(n_tready - base), 32'd1);
        check("bpsk_no_invalid", 32'(last_frame_inv), 32'd0);

        // cfg_enable drop and mode change mid-frame; extra byte stays queued
        cfg_is_bpsk = 1'b0;
        push_preamble();
        push_byte(8'hB4, 1'b0, 1'b0);
        push_byte(8'h1E, 1'b1, 1'b0);
        src_q.push_back({1'b1, 8'h55});
        base = n_tready;
        wait_tready(base + 1, "cfgoff");
        cfg_enable = 1'b0;
        cfg_is_bpsk = 1'b1;
        wait_done(3, "cfgoff");
        wait_slots(GAP_SYMS + 6);
        check("cfgoff_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("cfgoff_idle_busy", 32'(busy), 32'd0);
        check("cfgoff_idle_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("cfgoff_s_tvalid_held", 32'(bus.s_tvalid), 32'd1);
        check("cfgoff_bytes_taken", 32'(n_tready - base), 32'd2);
        src_q.delete();
        cfg_is_bpsk = 1'b0;
        @(posedge clk); #2;

        // Two frames queued back to back
        push_preamble();
        push_byte(8'hB4, 1'b0, 1'b0);
        push_byte(8'h1E, 1'b1, 1'b0);
        push_preamble();
        push_byte(8'h3C, 1'b1, 1'b0);
        cfg_enable = 1'b1;
        wait_done(5, "b2b");
        check("b2b_restart_spacing", 32'(last_gap), 32'(GAP_SYMS + 2));
        check("b2b_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_underrun_clear", 32'(underrun), 32'd0);

        // Withhold the second byte for three slots
        push_preamble();
        push_byte(8'hB4, 1'b0, 1'b0);
        cyc = 0;
        while (underrun !== 1'b1 && cyc < 4000) begin @(posedge clk); #2; cyc++; end
        check("underrun_raised", 32'(underrun), 32'd1);
        s = slot_cnt;
        while (slot_cnt < s + 2 && cyc < 8000) begin @(posedge clk); #2; cyc++; end
        push_byte(8'h1E, 1'b1, 1'b0);
        wait_done(6, "underrun");
        check("underrun_gap_symbols", 32'(last_frame_inv), 32'd3);
        check("underrun_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        wait_slots(4);
        check("underrun_sticky", 32'(underrun), 32'd1);

        // Reset in the middle of the payload
        push_preamble();
        push_byte(8'hB4, 1'b0, 1'b0);
        push_byte(8'h1E, 1'b1, 1'b0);
        base = n_tready;
        dbase = n_done;
        wait_tready(base + 1, "midrst");
        wait_slots(2);
        cfg_enable = 1'b0;
        src_q.delete();
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("midrst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("midrst_m_tdata",  32'(bus.m_tdata),  32'd0);
        check("midrst_m_tlast_user", {30'b0, bus.m_tlast, bus.m_tuser}, 32'd0);
        check("midrst_busy",     32'(busy),        32'd0);
        check("midrst_underrun", 32'(underrun),    32'd0);
        check("midrst_no_done",  32'(n_done),      32'(dbase));
        exp_q.delete();
        @(posedge clk); #2;
        push_preamble();
        push_byte(8'h3C, 1'b1, 1'b0);
        cfg_enable = 1'b1;
        wait_done(dbase + 1, "postrst");
        check("postrst_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("postrst_no_invalid", 32'(last_frame_inv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
